// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle for the bit-serial ALU.
// The ovf signal exists only when ALU_SERIAL_OVF_EN is defined.
interface alu_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef ALU_SERIAL_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, op,
      input  busy, done, s, cout, ovf
   );

   modport slave (
      input  start, a, b, op,
      output busy, done, s, cout, ovf
   );
`else
   modport master (
      output start, a, b, op,
      input  busy, done, s, cout
   );

   modport slave (
      input  start, a, b, op,
      output busy, done, s, cout
   );
`endif
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU (ADD/SUB/OR/XOR), one result bit per clock, LSB first, through a
// single 1-bit slice with registered carry. Optional signed overflow: ALU_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; s/cout hold the last result
// RUN   | one slice evaluation per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, result valid
module alu_serial #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   alu_serial_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             busy_c;
   logic             done_c;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_q;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt;
   logic             c_q;
   logic             cout_q;

   logic             accept;
   logic             last;
   logic             arith;
   logic             a_bit;
   logic             b_bit;
   logic             sum_bit;
   logic             carry_n;
   logic             res_bit;
   logic             c_next;

   assign accept = (state == IDLE) && bus.start;
   assign last   = (cnt == CNT_LAST);

   // Slice: SUB is a + ~b + 1, the +1 coming from the carry preload at start.
   assign arith   = ~op_q[1];
   assign a_bit   = a_sr[0];
   assign b_bit   = b_sr[0] ^ (op_q == OP_SUB);
   assign sum_bit = a_bit ^ b_bit ^ c_q;
   assign carry_n = (a_bit & b_bit) | (a_bit & c_q) | (b_bit & c_q);
   assign res_bit = arith ? sum_bit : (op_q[0] ? (a_sr[0] ^ b_sr[0]) : (a_sr[0] | b_sr[0]));
   assign c_next  = arith & carry_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         s_q    <= '0;
         op_q   <= OP_ADD;
         cnt    <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
      end else if (accept) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         s_q    <= '0;
         op_q   <= bus.op;
         cnt    <= '0;
         c_q    <= (bus.op == OP_SUB);
         cout_q <= 1'b0;
      end else if (state == RUN) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         s_q  <= {res_bit, s_q[WIDTH-1:1]};
         cnt  <= cnt + 1'b1;
         c_q  <= c_next;
         if (last) begin
            cout_q <= c_next;
         end
      end
   end

`ifdef ALU_SERIAL_OVF_EN
   logic ovf_q;

   // On the last slice c_q is the carry into the MSB and carry_n the carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if ((state == RUN) && last) begin
         ovf_q <= arith & (c_q ^ carry_n);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.s    = s_q;
   assign bus.cout = cout_q;
endmodule
